// File: rtl/and_result_packer.sv
// Packs serially sampled DUV output bits (LSB first) into WIDTH-bit words.
// Words queue in a first-word-fall-through FIFO with valid/ready drain and drop accounting.
module and_result_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         y_in,
  input  logic                         y_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] sh_q, sh_d, word_w;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             push, pop, full, accept, drop;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic [CW-1:0]    ones_w;

  // The pushed word includes a bit sampled in the same cycle; flush and
  // natural completion collapse into the single push signal.
  always_comb begin
    word_w = sh_q;
    if (y_valid) word_w[bcnt_q] = y_in;
    push = (y_valid && (bcnt_q == BW'(WIDTH - 1))) ||
           (flush && ((bcnt_q != '0) || y_valid));
    sh_d   = word_w;
    bcnt_d = bcnt_q;
    if (push) begin
      sh_d   = '0;
      bcnt_d = '0;
    end else if (y_valid) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a push to a full FIFO survives.
    accept    = push && (!full || pop);
    drop      = push && full && !pop;
    level_d   = level_q;
    if (accept && !pop)      level_d = level_q + 1'b1;
    else if (!accept && pop) level_d = level_q - 1'b1;
    ovf_d  = ovf_q | drop;
    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    ones_w   = '0;
    for (int i = 0; i < WIDTH; i++) ones_w = ones_w + CW'(out_data[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= word_w;
  end

  assign out_ones = ones_w;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule
